gemm_operand_loader: RTL and testbench
======================================

# gemm_operand_loader

Streams GEMM operands in from a single word-wide valid/ready channel, assembles alpha, beta and the A, B, C matrices into holding registers, and presents the complete operand set to the GEMM compute stage with a valid/ack handshake. Sits directly upstream of the GEMM core. It converts a serial host/DMA stream into the parallel matrix operands the core consumes in one cycle.

## Interface
- DATA_WIDTH, 32, element and scalar width
- MATRIX_HEIGHT, 4, rows per matrix
- MATRIX_WIDTH, 4, columns per matrix
- iclk  in  1  clock, all logic on rising edge
- irst  in  1  reset; synchronous, active-high
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  DATA_WIDTH  stream word
- s_last  in  1  marks final word of a frame
- alpha, beta  out  DATA_WIDTH each  captured scalars
- a_flat, b_flat, c_flat  out  DATA_WIDTH*MATRIX_HEIGHT*MATRIX_WIDTH each  matrices; element [i][j] at bits (i*MATRIX_WIDTH+j)*DATA_WIDTH +: DATA_WIDTH
- load_valid  out  1  full operand set held and stable
- load_ack  in  1  consumer has captured operands
- frame_err  out  1  one-cycle pulse on a malformed frame

## Operation
- Frame: N = 2 + 3*H*W words (50 at defaults), in this order: alpha, beta, A row-major, B row-major, C row-major. s_last is set on word N only.
- A word transfers when s_valid && s_ready on a rising edge.
- FSM states: ST_ALPHA, ST_BETA, ST_A, ST_B, ST_C, ST_HOLD, ST_DRAIN.
  - ST_ALPHA → ST_BETA → ST_A after one transfer each.
  - ST_A, ST_B and ST_C each take H*W transfers, indexed by element counter idx (0..H*W-1). idx wraps to 0 when the state advances.
  - ST_C → ST_HOLD on its final transfer, if s_last = 1.
  - ST_HOLD → ST_ALPHA on load_ack.
- Each transfer writes s_data into the slot selected by state/idx. No arithmetic and no width conversion are applied.
- s_ready = 1 in ST_ALPHA..ST_C and ST_DRAIN. s_ready = 0 in ST_HOLD and whenever irst = 1.
- load_valid = 1 exactly in ST_HOLD. All operand outputs are stable for the whole of ST_HOLD.
- Early s_last (set on any word before N): that word is discarded, frame_err pulses, and the FSM goes to ST_ALPHA. Registers already written are left as is, but load_valid does not assert.
- Missing s_last (word N arrives with s_last = 0): frame_err pulses and the FSM goes to ST_DRAIN. ST_DRAIN discards words until it accepts a word with s_last = 1, then goes to ST_ALPHA. frame_err does not pulse again during the drain.
- load_ack outside ST_HOLD is ignored.
- After ST_HOLD exits, operand registers may be overwritten by the next frame. The consumer must capture them on the ack cycle.

## Timing
- Reset: state = ST_ALPHA, idx = 0. alpha, beta, a_flat, b_flat, c_flat = 0. load_valid = 0, frame_err = 0, s_ready = 0 during reset.
- s_ready = 1 in the first cycle after irst deasserts.
- Back-to-back streaming at one word per cycle is supported. Minimum frame load time is N cycles.
- load_valid rises in the cycle after word N transfers. Latency is 1 cycle from the last accepted word.
- load_ack sampled high in ST_HOLD: the next cycle has load_valid = 0 and s_ready = 1. Minimum gap between frames is 1 cycle.
- frame_err is registered. It is high in the cycle after the offending transfer.
- irst in any state, including mid-frame or ST_HOLD, wins over every other input. The partial frame is lost.

## Structure
- Shared package gemm_pkg: default DATA_WIDTH/MATRIX_* constants, the state enum, the FRAME_WORDS = 2+3*H*W localparam, and the flat-index helper function (i*W+j).
- Sub-module gemm_matrix_buf is natural. It is an H*W register bank with write enable, write index and flat read-out, instantiated three times for A, B and C. The FSM and the scalar registers stay in the top.

## Test plan
- Reset then a clean frame: alpha = 2, beta = 3, A[i][j] = i*4+j, B = 16+k, C = 32+k, streamed at 1 word/cycle → load_valid rises in the cycle after word 50. a_flat[5] = 5, b_flat[0] = 16, c_flat[15] = 47, alpha = 2, beta = 3. s_ready = 0 until ack.
- Hold and ack: keep load_ack = 0 for 10 cycles while s_valid = 1 → no words accepted and outputs constant. Pulse load_ack → load_valid = 0 and s_ready = 1 on the next cycle.
- Early s_last set on word 20 → frame_err pulses once, load_valid stays 0. A following clean frame loads correctly.
- Missing s_last on word 50, then 7 garbage words with s_last on the 7th → one frame_err pulse and 7 words discarded. The next clean frame loads correctly.
- Random s_valid gaps (about 50% duty) over a full frame → same outputs as the first scenario.
- irst asserted at word 30 and in ST_HOLD → all outputs 0 and state ST_ALPHA. A fresh frame then loads correctly.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared defaults, loader FSM state type and the row-major flat-index helper
// used by the GEMM operand loader and its matrix buffers.
package gemm_pkg;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_MATRIX_HEIGHT = 4;
    localparam int DEF_MATRIX_WIDTH  = 4;
    localparam int FRAME_WORDS       = 2 + 3*DEF_MATRIX_HEIGHT*DEF_MATRIX_WIDTH;

    typedef enum logic [2:0] {ST_ALPHA, ST_BETA, ST_A, ST_B, ST_C, ST_HOLD, ST_DRAIN} state_t;

    function automatic int flat_idx(input int i, input int j, input int w = DEF_MATRIX_WIDTH);
        return i*w + j;
    endfunction
endpackage

// File: rtl/gemm_matrix_buf.sv
// gemm_matrix_buf: H*W element register bank written one element at a time,
// read out as a single flat row-major vector.
module gemm_matrix_buf #(
    parameter int DW = 32,
    parameter int H  = 4,
    parameter int W  = 4,
    parameter int IW = 4
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              we_i,
    input  logic [IW-1:0]     widx_i,
    input  logic [DW-1:0]     wdata_i,
    output logic [DW*H*W-1:0] flat_o
);
    logic [DW*H*W-1:0] flat_q;

    always_ff @(posedge iclk) begin
        if (irst)
            flat_q <= '0;
        else if (we_i)
            flat_q[widx_i*DW +: DW] <= wdata_i;
    end

    assign flat_o = flat_q;
endmodule

// File: rtl/gemm_operand_loader.sv
// gemm_operand_loader: assembles alpha, beta, A, B, C from a word stream and holds the
// complete operand set for the GEMM core until it is acknowledged.
module gemm_operand_loader
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MATRIX_HEIGHT = DEF_MATRIX_HEIGHT,
    parameter int MATRIX_WIDTH  = DEF_MATRIX_WIDTH
) (
    input  logic                                          iclk,
    input  logic                                          irst,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [DATA_WIDTH-1:0]                         s_data,
    input  logic                                          s_last,
    output logic [DATA_WIDTH-1:0]                         alpha,
    output logic [DATA_WIDTH-1:0]                         beta,
    output logic [DATA_WIDTH*MATRIX_HEIGHT*MATRIX_WIDTH-1:0] a_flat,
    output logic [DATA_WIDTH*MATRIX_HEIGHT*MATRIX_WIDTH-1:0] b_flat,
    output logic [DATA_WIDTH*MATRIX_HEIGHT*MATRIX_WIDTH-1:0] c_flat,
    output logic                                          load_valid,
    input  logic                                          load_ack,
    output logic                                          frame_err
);
    localparam int HW = MATRIX_HEIGHT*MATRIX_WIDTH;
    localparam int IW = HW > 1 ? $clog2(HW) : 1;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
    logic                  err_q, err_d;
    logic                  xfer, idx_end, frame_end, in_mat, early;
    logic                  we_a, we_b, we_c;

    assign s_ready    = !irst && state_q != ST_HOLD;
    assign xfer       = s_valid && s_ready;
    assign idx_end    = idx_q == IW'(HW-1);
    assign frame_end  = state_q == ST_C && idx_end;
    assign in_mat     = state_q == ST_A || state_q == ST_B || state_q == ST_C;
    // an s_last anywhere but the final word aborts the frame without writing that word
    assign early      = xfer && state_q != ST_DRAIN && s_last && !frame_end;
    assign we_a       = xfer && !early && state_q == ST_A;
    assign we_b       = xfer && !early && state_q == ST_B;
    assign we_c       = xfer && !early && state_q == ST_C;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        alpha_d = xfer && !early && state_q == ST_ALPHA ? s_data : alpha_q;
        beta_d  = xfer && !early && state_q == ST_BETA ? s_data : beta_q;
        if (state_q == ST_HOLD) begin
            state_d = load_ack ? ST_ALPHA : ST_HOLD;
        end else if (early) begin
            state_d = ST_ALPHA;
            idx_d   = '0;
            err_d   = 1'b1;
        end else if (xfer) begin
            unique case (state_q)
                ST_ALPHA: state_d = ST_BETA;
                ST_BETA:  state_d = ST_A;
                ST_A:     state_d = idx_end ? ST_B : ST_A;
                ST_B:     state_d = idx_end ? ST_C : ST_B;
                ST_C:     state_d = !idx_end ? ST_C : s_last ? ST_HOLD : ST_DRAIN;
                ST_DRAIN: state_d = s_last ? ST_ALPHA : ST_DRAIN;
                default:  state_d = ST_ALPHA;
            endcase
            idx_d = in_mat ? (idx_end ? '0 : idx_q + 1'b1) : idx_q;
            err_d = frame_end && !s_last;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= ST_ALPHA;
            idx_q   <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
            err_q   <= err_d;
        end
    end

    gemm_matrix_buf #(.DW(DATA_WIDTH), .H(MATRIX_HEIGHT), .W(MATRIX_WIDTH), .IW(IW)) u_buf_a (
        .iclk(iclk), .irst(irst), .we_i(we_a), .widx_i(idx_q), .wdata_i(s_data), .flat_o(a_flat)
    );
    gemm_matrix_buf #(.DW(DATA_WIDTH), .H(MATRIX_HEIGHT), .W(MATRIX_WIDTH), .IW(IW)) u_buf_b (
        .iclk(iclk), .irst(irst), .we_i(we_b), .widx_i(idx_q), .wdata_i(s_data), .flat_o(b_flat)
    );
    gemm_matrix_buf #(.DW(DATA_WIDTH), .H(MATRIX_HEIGHT), .W(MATRIX_WIDTH), .IW(IW)) u_buf_c (
        .iclk(iclk), .irst(irst), .we_i(we_c), .widx_i(idx_q), .wdata_i(s_data), .flat_o(c_flat)
    );

    assign alpha      = alpha_q;
    assign beta       = beta_q;
    assign load_valid = !irst && state_q == ST_HOLD;
    assign frame_err  = !irst && err_q;
endmodule

// File: tb/tb_gemm_operand_loader.sv
// tb_gemm_operand_loader: directed scenarios with random data/gaps, checked against a
// word-position model of the frame format.
module tb_gemm_operand_loader;
    import gemm_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int HW = DEF_MATRIX_HEIGHT*DEF_MATRIX_WIDTH;
    localparam int N  = FRAME_WORDS;
    localparam int FW = DW*HW;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          load_ack = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, load_valid, frame_err;
    logic [DW-1:0] alpha, beta;
    logic [FW-1:0] a_flat, b_flat, c_flat;

    gemm_operand_loader dut (
        .iclk(iclk), .irst(irst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .alpha(alpha), .beta(beta), .a_flat(a_flat), .b_flat(b_flat),
        .c_flat(c_flat), .load_valid(load_valid), .load_ack(load_ack), .frame_err(frame_err)
    );

    always #5 iclk = ~iclk;

    int errors = 0;
    int checks = 0;

    // model: every frame word has a fixed slot; slot[] is what the operand registers hold
    logic [DW-1:0] slot [N];
    int pos;
    bit drain, hold, exp_err;

    task automatic chkw(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_mat(input int base);
        logic [FW-1:0] r;
        for (int k = 0; k < HW; k++) r[k*DW +: DW] = slot[base+k];
        return r;
    endfunction

    function automatic logic [DW-1:0] pattern(input int k);
        return k == 0 ? DW'(2) : k == 1 ? DW'(3) : DW'(k-2);
    endfunction

    task automatic chk_state(input string tag);
        chk1({tag, ".load_valid"}, load_valid, hold);
        chk1({tag, ".s_ready"}, s_ready, !hold);
        chk1({tag, ".frame_err"}, frame_err, exp_err);
    endtask

    task automatic chk_ops(input string tag);
        chkw({tag, ".alpha"}, FW'(alpha), FW'(slot[0]));
        chkw({tag, ".beta"}, FW'(beta), FW'(slot[1]));
        chkw({tag, ".a_flat"}, a_flat, exp_mat(2));
        chkw({tag, ".b_flat"}, b_flat, exp_mat(2+HW));
        chkw({tag, ".c_flat"}, c_flat, exp_mat(2+2*HW));
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        exp_err = 0;
        if (drain) begin
            if (l) drain = 0;
        end else if (l && pos < N-1) begin
            exp_err = 1;
            pos = 0;
        end else begin
            slot[pos] = d;
            if (pos == N-1) begin
                pos = 0;
                if (l) hold = 1;
                else begin
                    exp_err = 1;
                    drain = 1;
                end
            end else pos++;
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l, input bit gaps);
        int n;
        logic rdy;
        if (gaps) while ($urandom_range(0, 1) == 0) begin
            s_valid = 1'b0;
            @(posedge iclk); #1;
            exp_err = 0;
        end
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        n = 0;
        forever begin
            @(negedge iclk);
            rdy = s_ready;
            @(posedge iclk); #1;
            if (rdy) break;
            n++;
            if (n > 100) begin
                errors++;
                $error("FAIL push_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (rdy) begin
            model_accept(d, l);
            chk_state("word");
        end
    endtask

    task automatic send_frame(input int last_at, input bit gaps, input bit rnd);
        int cnt;
        cnt = last_at == 0 ? N : last_at;
        for (int k = 0; k < cnt; k++)
            push(rnd ? DW'($urandom) : pattern(k), k == cnt-1 && last_at != 0, gaps);
    endtask

    task automatic idle(input string tag);
        s_valid = 1'b0;
        @(posedge iclk); #1;
        exp_err = 0;
        chk_state(tag);
    endtask

    task automatic do_reset(input string tag);
        irst = 1'b1;
        #1 chk1({tag, ".s_ready_in_rst"}, s_ready, 1'b0);
        @(posedge iclk); #1;
        for (int k = 0; k < N; k++) slot[k] = '0;
        pos = 0;
        drain = 0;
        hold = 0;
        exp_err = 0;
        chk1({tag, ".load_valid"}, load_valid, 1'b0);
        chk1({tag, ".frame_err"}, frame_err, 1'b0);
        chk_ops(tag);
        s_valid = 1'b0;
        load_ack = 1'b0;
        irst = 1'b0;
        #1 chk1({tag, ".s_ready_after"}, s_ready, 1'b1);
    endtask

    task automatic ack(input string tag);
        load_ack = 1'b1;
        @(posedge iclk); #1;
        load_ack = 1'b0;
        hold = 0;
        exp_err = 0;
        chk_state(tag);
    endtask

    task automatic spot(input string tag);
        chkw({tag, ".a5"}, FW'(a_flat[flat_idx(1, 1)*DW +: DW]), FW'(5));
        chkw({tag, ".b0"}, FW'(b_flat[flat_idx(0, 0)*DW +: DW]), FW'(16));
        chkw({tag, ".c15"}, FW'(c_flat[flat_idx(3, 3)*DW +: DW]), FW'(47));
        chkw({tag, ".alpha2"}, FW'(alpha), FW'(2));
        chkw({tag, ".beta3"}, FW'(beta), FW'(3));
    endtask

    initial begin
        do_reset("reset0");

        send_frame(N, 0, 0);
        spot("clean");
        chk_ops("clean");

        s_valid = 1'b1;
        s_data = DW'($urandom);
        for (int c = 0; c < 10; c++) begin
            @(posedge iclk); #1;
            chk_state("hold");
            chk_ops("hold");
        end
        s_valid = 1'b0;
        ack("ack1");

        load_ack = 1'b1;
        idle("stray_ack");
        load_ack = 1'b0;

        send_frame(20, 0, 0);
        idle("early_after");
        send_frame(N, 0, 0);
        chk_ops("after_early");
        ack("ack2");

        send_frame(0, 0, 1);
        for (int g = 0; g < 7; g++) push(DW'($urandom), g == 6, 0);
        idle("drain_after");
        send_frame(N, 0, 1);
        chk_ops("after_drain");
        ack("ack3");

        send_frame(N, 1, 0);
        spot("gaps");
        chk_ops("gaps");
        ack("ack4");

        send_frame(N, 1, 1);
        chk_ops("rnd_gaps");
        ack("ack5");

        for (int k = 0; k < 29; k++) push(DW'($urandom), 1'b0, 0);
        s_valid = 1'b1;
        s_data = DW'($urandom);
        do_reset("reset_mid");
        send_frame(N, 0, 1);
        chk_ops("after_rst_mid");

        load_ack = 1'b1;
        do_reset("reset_hold");
        send_frame(N, 0, 1);
        chk_ops("after_rst_hold");
        ack("ack6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
